// File: rtl/local_mem_arbiter.sv
// local_mem_arbiter: round-robin share of one local_mem port with index-tagged response routing and read throttling
module local_mem_arbiter #(
   parameter int NUM_REQS        = 2,
   parameter int ADDR_W          = 26,
   parameter int DATA_W          = 512,
   parameter int BYTEEN_W        = 64,
   parameter int TAG_W           = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int IDX_W           = $clog2(NUM_REQS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQS-1:0]          req_valid,
   input  logic [NUM_REQS-1:0]          req_rw,
   input  logic [NUM_REQS*BYTEEN_W-1:0] req_byteen,
   input  logic [NUM_REQS*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQS*DATA_W-1:0]   req_data,
   input  logic [NUM_REQS*TAG_W-1:0]    req_tag,
   output logic [NUM_REQS-1:0]          req_ready,
   output logic [NUM_REQS-1:0]          rsp_valid,
   output logic [DATA_W-1:0]            rsp_data,
   output logic [TAG_W-1:0]             rsp_tag,
   input  logic [NUM_REQS-1:0]          rsp_ready,
   output logic                         mem_req_valid,
   output logic                         mem_req_rw,
   output logic [BYTEEN_W-1:0]          mem_req_byteen,
   output logic [ADDR_W-1:0]            mem_req_addr,
   output logic [DATA_W-1:0]            mem_req_data,
   output logic [TAG_W+IDX_W-1:0]       mem_req_tag,
   input  logic                         mem_req_ready,
   input  logic                         mem_rsp_valid,
   input  logic [DATA_W-1:0]            mem_rsp_data,
   input  logic [TAG_W+IDX_W-1:0]       mem_rsp_tag,
   output logic                         mem_rsp_ready,
   output logic                         busy
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
   logic [IDX_W-1:0] rr_gnt, cand, gnt, rsp_idx;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [NUM_REQS-1:0] elig;
   logic throttle, any_elig, gnt_valid, req_xfer, rsp_xfer;
   always_comb begin
      throttle = outstanding_q == CNT_W'(MAX_OUTSTANDING);
      elig     = req_valid & ~({NUM_REQS{throttle}} & ~req_rw);
      rr_gnt   = rr_ptr_q;
      cand     = rr_ptr_q;
      any_elig = 1'b0;
      // descending scan so the eligible requester closest to rr_ptr wins
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
         cand = rr_ptr_q + IDX_W'(k);
         if (elig[cand]) begin
            rr_gnt   = cand;
            any_elig = 1'b1;
         end
      end
      gnt            = (state_q == LOCKED) ? lock_idx_q : rr_gnt;
      gnt_valid      = (state_q == LOCKED) ? req_valid[lock_idx_q] : any_elig;
      mem_req_valid  = !reset && gnt_valid;
      mem_req_rw     = !reset && req_rw[gnt];
      mem_req_byteen = reset ? '0 : req_byteen[int'(gnt)*BYTEEN_W +: BYTEEN_W];
      mem_req_addr   = reset ? '0 : req_addr[int'(gnt)*ADDR_W +: ADDR_W];
      mem_req_data   = reset ? '0 : req_data[int'(gnt)*DATA_W +: DATA_W];
      mem_req_tag    = reset ? '0 : {gnt, req_tag[int'(gnt)*TAG_W +: TAG_W]};
      req_ready      = reset ? '0 : NUM_REQS'(gnt_valid && mem_req_ready) << gnt;
      req_xfer       = mem_req_valid && mem_req_ready;
      rsp_idx        = mem_rsp_tag[TAG_W+IDX_W-1:TAG_W];
      rsp_valid      = reset ? '0 : NUM_REQS'(mem_rsp_valid) << rsp_idx;
      rsp_data       = reset ? '0 : mem_rsp_data;
      rsp_tag        = reset ? '0 : mem_rsp_tag[TAG_W-1:0];
      mem_rsp_ready  = !reset && rsp_ready[rsp_idx];
      rsp_xfer       = mem_rsp_valid && mem_rsp_ready;
      busy           = !reset && (outstanding_q != '0 || state_q == LOCKED);
      outstanding_d  = outstanding_q + CNT_W'(req_xfer && !mem_req_rw)
                     - CNT_W'(rsp_xfer && outstanding_q != '0);
      state_d        = (gnt_valid && !mem_req_ready) ? LOCKED : IDLE;
      lock_idx_d     = gnt;
      rr_ptr_d       = req_xfer ? gnt + 1'b1 : rr_ptr_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         lock_idx_q    <= '0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         lock_idx_q    <= lock_idx_d;
         outstanding_q <= outstanding_d;
      end
   end
endmodule

// File: tb/tb_local_mem_arbiter.sv
// tb_local_mem_arbiter: directed vectors with hand-computed expectations for local_mem_arbiter
module tb_local_mem_arbiter;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    req_valid = '0, req_rw = '0, req_ready, rsp_valid, rsp_ready = 2'b11;
   logic [127:0]  req_byteen = {64'hF0, 64'h0F};
   logic [51:0]   req_addr = {26'h40, 26'h100};
   logic [1023:0] req_data = {512'hD1, 512'hD0};
   logic [15:0]   req_tag = {8'hA5, 8'h3C};
   logic [511:0]  rsp_data, mem_req_data, mem_rsp_data = 512'hCAFE;
   logic [7:0]    rsp_tag;
   logic          mem_req_valid, mem_req_rw, mem_req_ready = 1'b0;
   logic [63:0]   mem_req_byteen;
   logic [25:0]   mem_req_addr;
   logic [8:0]    mem_req_tag, mem_rsp_tag = '0;
   logic          mem_rsp_valid = 1'b0, mem_rsp_ready, busy;
   int            checks = 0, errors = 0;
   local_mem_arbiter dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen),
      .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic rst, input logic [1:0] rv, input logic [1:0] rw, input logic mrr,
                        input logic mrv, input logic [8:0] mrt, input logic [1:0] rrdy);
      @(posedge clk);
      #1;
      reset = rst; req_valid = rv; req_rw = rw; mem_req_ready = mrr;
      mem_rsp_valid = mrv; mem_rsp_tag = mrt; rsp_ready = rrdy;
      #2;
   endtask
   initial begin
      for (int i = 0; i < 13; i++) begin
         drive(1, 2'b11, 2'b00, 1, 0, 9'h0, 2'b11);
         check("rst_req_ready", req_ready, 0);
         check("rst_mem_req_valid", mem_req_valid, 0);
         check("rst_mem_rsp_ready", mem_rsp_ready, 0);
         check("rst_busy", busy, 0);
      end
      drive(0, 2'b11, 2'b00, 1, 0, 9'h0, 2'b11);
      check("a_valid", mem_req_valid, 1);
      check("a_ready", req_ready, 2'b01);
      check("a_tag", mem_req_tag, 9'h03C);
      check("a_addr", mem_req_addr, 26'h100);
      check("a_byteen", mem_req_byteen, 64'h0F);
      check("a_data", mem_req_data[63:0], 64'hD0);
      check("a_busy", busy, 0);
      drive(0, 2'b11, 2'b00, 1, 0, 9'h0, 2'b11);
      check("b_ready", req_ready, 2'b10);
      check("b_tag", mem_req_tag, 9'h1A5);
      check("b_addr", mem_req_addr, 26'h40);
      check("b_busy", busy, 1);
      drive(0, 2'b11, 2'b00, 1, 1, 9'h03C, 2'b11);
      check("c_tag", mem_req_tag, 9'h03C);
      check("c_rsp_valid", rsp_valid, 2'b01);
      check("c_rsp_tag", rsp_tag, 8'h3C);
      check("c_rsp_data", rsp_data[63:0], 64'hCAFE);
      check("c_mem_rsp_ready", mem_rsp_ready, 1);
      drive(0, 2'b11, 2'b00, 1, 1, 9'h1A5, 2'b11);
      check("d_tag", mem_req_tag, 9'h1A5);
      check("d_rsp_valid", rsp_valid, 2'b10);
      check("d_rsp_tag", rsp_tag, 8'hA5);
      drive(0, 2'b00, 2'b00, 1, 1, 9'h03C, 2'b11);
      check("e_valid", mem_req_valid, 0);
      check("e_busy", busy, 1);
      drive(0, 2'b00, 2'b00, 1, 1, 9'h1A5, 2'b11);
      check("f_busy", busy, 1);
      drive(0, 2'b00, 2'b00, 1, 0, 9'h0, 2'b11);
      check("g_busy_drained", busy, 0);
      drive(0, 2'b01, 2'b01, 1, 0, 9'h0, 2'b11);
      check("w_ready", req_ready, 2'b01);
      check("w_rw", mem_req_rw, 1);
      drive(0, 2'b11, 2'b00, 0, 0, 9'h0, 2'b11);
      check("l1_valid", mem_req_valid, 1);
      check("l1_tag", mem_req_tag, 9'h1A5);
      check("l1_addr", mem_req_addr, 26'h40);
      check("l1_ready", req_ready, 0);
      check("l1_busy", busy, 0);
      for (int i = 0; i < 2; i++) begin
         drive(0, 2'b11, 2'b00, 0, 0, 9'h0, 2'b11);
         check("lk_tag", mem_req_tag, 9'h1A5);
         check("lk_ready", req_ready, 0);
         check("lk_busy", busy, 1);
      end
      drive(0, 2'b11, 2'b00, 1, 0, 9'h0, 2'b11);
      check("l4_ready", req_ready, 2'b10);
      check("l4_tag", mem_req_tag, 9'h1A5);
      for (int i = 0; i < 3; i++) begin
         drive(0, 2'b01, 2'b00, 1, 0, 9'h0, 2'b11);
         check("fill_ready", req_ready, 2'b01);
         check("fill_busy", busy, 1);
      end
      drive(0, 2'b01, 2'b00, 1, 0, 9'h0, 2'b11);
      check("thr_valid", mem_req_valid, 0);
      check("thr_ready", req_ready, 0);
      check("thr_busy", busy, 1);
      drive(0, 2'b11, 2'b10, 1, 0, 9'h0, 2'b11);
      check("thr_wr_ready", req_ready, 2'b10);
      check("thr_wr_rw", mem_req_rw, 1);
      check("thr_wr_tag", mem_req_tag, 9'h1A5);
      drive(0, 2'b01, 2'b00, 1, 1, 9'h03C, 2'b11);
      check("thr_rsp_valid", mem_req_valid, 0);
      check("thr_rsp_ready", mem_rsp_ready, 1);
      drive(0, 2'b01, 2'b00, 1, 0, 9'h0, 2'b11);
      check("unthr_ready", req_ready, 2'b01);
      for (int i = 0; i < 2; i++) begin
         drive(0, 2'b00, 2'b00, 1, 1, 9'h1A5, 2'b01);
         check("bp_mem_rsp_ready", mem_rsp_ready, 0);
         check("bp_rsp_valid", rsp_valid, 2'b10);
         check("bp_rsp_tag", rsp_tag, 8'hA5);
      end
      drive(0, 2'b00, 2'b00, 1, 1, 9'h1A5, 2'b11);
      check("bp_accept", mem_rsp_ready, 1);
      drive(0, 2'b01, 2'b00, 1, 0, 9'h0, 2'b11);
      check("bp_refill_ready", req_ready, 2'b01);
      drive(0, 2'b01, 2'b00, 1, 0, 9'h0, 2'b11);
      check("bp_full_valid", mem_req_valid, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 2'b00, 2'b00, 1, 1, 9'h03C, 2'b11);
         check("drain_busy", busy, 1);
      end
      drive(0, 2'b00, 2'b00, 1, 1, 9'h03C, 2'b11);
      check("uf_busy", busy, 0);
      check("uf_mem_rsp_ready", mem_rsp_ready, 1);
      drive(0, 2'b00, 2'b00, 1, 0, 9'h0, 2'b11);
      check("uf_busy_after", busy, 0);
      drive(0, 2'b10, 2'b00, 0, 0, 9'h0, 2'b11);
      check("drop_valid", mem_req_valid, 1);
      check("drop_ready", req_ready, 0);
      drive(0, 2'b00, 2'b00, 0, 0, 9'h0, 2'b11);
      check("drop_no_valid", mem_req_valid, 0);
      check("drop_busy_locked", busy, 1);
      drive(0, 2'b00, 2'b00, 0, 0, 9'h0, 2'b11);
      check("drop_busy_idle", busy, 0);
      drive(0, 2'b01, 2'b00, 1, 0, 9'h0, 2'b11);
      check("mr_ready", req_ready, 2'b01);
      drive(1, 2'b11, 2'b00, 1, 0, 9'h0, 2'b11);
      check("mr_rst_ready", req_ready, 0);
      check("mr_rst_valid", mem_req_valid, 0);
      drive(0, 2'b00, 2'b00, 1, 1, 9'h1A5, 2'b11);
      check("mr_busy", busy, 0);
      check("mr_rsp_ready", mem_rsp_ready, 1);
      drive(0, 2'b00, 2'b00, 1, 0, 9'h0, 2'b11);
      check("mr_busy_after", busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
